// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide SPI master.
// Optional HOLD timeout is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int unsigned IDLE_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_req,
  input  logic       r1_req,
  output logic       r0_gnt,
  output logic       r1_gnt,
  input  logic       r0_tx_valid,
  input  logic [7:0] r0_tx_data,
  input  logic       r0_last,
  input  logic       r1_tx_valid,
  input  logic [7:0] r1_tx_data,
  input  logic       r1_last,
  output logic       r0_tx_ready,
  output logic       r1_tx_ready,
  output logic       r0_rx_valid,
  output logic       r1_rx_valid,
  output logic [7:0] rx_data,
  output logic       m_start,
  output logic [7:0] m_tx_data,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic [7:0] m_rx_data,
  output logic       ss_n,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_HOLD,
    S_XFER,
    S_DESELECT
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        ss_n_q, ss_n_d;
  logic        m_start_q, m_start_d;
  logic [7:0]  m_tx_data_q, m_tx_data_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [1:0]  rx_valid_q, rx_valid_d;
  logic        active_d;
  logic        expire;
  logic        own_req, own_valid, own_last;
  logic [7:0]  own_data;
  logic        tx_ready_c;
  logic        accept;

  assign own_req   = owner_q ? r1_req      : r0_req;
  assign own_valid = owner_q ? r1_tx_valid : r0_tx_valid;
  assign own_last  = owner_q ? r1_last     : r0_last;
  assign own_data  = owner_q ? r1_tx_data  : r0_tx_data;

  // Ready follows m_busy in the same cycle so acceptance never races the master.
  assign tx_ready_c = (state_q == S_HOLD) && !m_busy && own_req && !expire;
  assign accept     = tx_ready_c && own_valid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    last_d      = last_q;
    m_start_d   = 1'b0;
    m_tx_data_d = m_tx_data_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          state_d = S_SELECT;
          owner_d = (r0_req && r1_req) ? rr_q : r1_req;
        end
      end
      S_SELECT: state_d = S_HOLD;
      S_HOLD: begin
        if (!own_req || expire) begin
          state_d = S_DESELECT;
        end else if (accept) begin
          state_d     = S_XFER;
          m_start_d   = 1'b1;
          m_tx_data_d = own_data;
          last_d      = own_last;
        end
      end
      S_XFER: begin
        if (m_done) begin
          rx_data_d  = m_rx_data;
          rx_valid_d = owner_q ? 2'b10 : 2'b01;
          state_d    = (last_q || !own_req) ? S_DESELECT : S_HOLD;
        end
      end
      S_DESELECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // The requester just served loses the next tie.
    if (state_d == S_DESELECT && state_q != S_DESELECT) begin
      rr_d = !owner_q;
    end
    active_d = (state_d == S_SELECT) || (state_d == S_HOLD) || (state_d == S_XFER);
    ss_n_d   = !active_d;
    gnt_d    = active_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      last_q      <= 1'b0;
      gnt_q       <= 2'b00;
      ss_n_q      <= 1'b1;
      m_start_q   <= 1'b0;
      m_tx_data_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ss_n_q      <= ss_n_d;
      m_start_q   <= m_start_d;
      m_tx_data_q <= m_tx_data_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (IDLE_LIMIT < 2) ? 1 : $clog2(IDLE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // cnt holds the number of HOLD cycles spent so far, restarting on each HOLD entry.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_d == S_HOLD) begin
      cnt_d     = (state_q == S_HOLD) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      timeout_d = (cnt_d == CNT_W'(IDLE_LIMIT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign expire  = timeout_q;
  assign timeout = timeout_q;
`else
  localparam int unsigned unused_idle_limit = IDLE_LIMIT;

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign r0_gnt      = gnt_q[0];
  assign r1_gnt      = gnt_q[1];
  assign r0_tx_ready = tx_ready_c && !owner_q;
  assign r1_tx_ready = tx_ready_c && owner_q;
  assign r0_rx_valid = rx_valid_q[0];
  assign r1_rx_valid = rx_valid_q[1];
  assign rx_data     = rx_data_q;
  assign m_start     = m_start_q;
  assign m_tx_data   = m_tx_data_q;
  assign ss_n        = ss_n_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter; the SPI master side is driven by hand.
// Timeout scenario is built only with `define SPI_ARB_TIMEOUT_EN.
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_req, r1_req, r0_gnt, r1_gnt;
  logic       r0_tx_valid, r1_tx_valid, r0_last, r1_last;
  logic [7:0] r0_tx_data, r1_tx_data;
  logic       r0_tx_ready, r1_tx_ready, r0_rx_valid, r1_rx_valid;
  logic [7:0] rx_data, m_tx_data, m_rx_data;
  logic       m_start, m_busy, m_done, ss_n, timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_arbiter #(.IDLE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r1_req(r1_req), .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_tx_valid(r0_tx_valid), .r0_tx_data(r0_tx_data), .r0_last(r0_last),
    .r1_tx_valid(r1_tx_valid), .r1_tx_data(r1_tx_data), .r1_last(r1_last),
    .r0_tx_ready(r0_tx_ready), .r1_tx_ready(r1_tx_ready),
    .r0_rx_valid(r0_rx_valid), .r1_rx_valid(r1_rx_valid), .rx_data(rx_data),
    .m_start(m_start), .m_tx_data(m_tx_data),
    .m_busy(m_busy), .m_done(m_done), .m_rx_data(m_rx_data),
    .ss_n(ss_n), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_req = 0; r1_req = 0; r0_tx_valid = 0; r1_tx_valid = 0;
    r0_last = 0; r1_last = 0; r0_tx_data = 0; r1_tx_data = 0;
    m_busy = 0; m_done = 0; m_rx_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Drives one byte from HOLD through m_done; returns just after the done edge.
  task automatic xfer_byte(input logic who, input logic [7:0] tx, input logic last,
                           input logic [7:0] rx);
    if (who) begin r1_tx_valid = 1; r1_tx_data = tx; r1_last = last; end
    else     begin r0_tx_valid = 1; r0_tx_data = tx; r0_last = last; end
    tick();
    r0_tx_valid = 0; r1_tx_valid = 0; r0_last = 0; r1_last = 0;
    m_busy = 1;
    tick();
    m_done = 1; m_rx_data = rx; m_busy = 0;
    tick();
    m_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({ss_n, r0_gnt, r1_gnt} !== 3'b100) begin failures++;
      $display("FAIL reset_sel got=%b exp=100", {ss_n, r0_gnt, r1_gnt}); end
    checks++; if ({r0_tx_ready, r1_tx_ready, r0_rx_valid, r1_rx_valid, m_start, timeout} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {r0_tx_ready, r1_tx_ready, r0_rx_valid, r1_rx_valid, m_start, timeout}); end
    checks++; if ({m_tx_data, rx_data} !== 16'h0000) begin failures++;
      $display("FAIL reset_data got=%h exp=0000", {m_tx_data, rx_data}); end
  endtask

  task automatic test_single();
    r0_req = 1;
    tick();
    checks++; if ({ss_n, r0_gnt, r1_gnt} !== 3'b010) begin failures++;
      $display("FAIL single_select got=%b exp=010", {ss_n, r0_gnt, r1_gnt}); end
    tick();
    r0_tx_valid = 1; r0_tx_data = 8'hA5; r0_last = 0;
    checks++; if ({r0_tx_ready, r1_tx_ready} !== 2'b10) begin failures++;
      $display("FAIL single_ready got=%b exp=10", {r0_tx_ready, r1_tx_ready}); end
    tick();
    checks++; if ({m_start, m_tx_data} !== {1'b1, 8'hA5}) begin failures++;
      $display("FAIL single_start0 got=%b/%h exp=1/a5", m_start, m_tx_data); end
    checks++; if (r0_tx_ready !== 1'b0) begin failures++;
      $display("FAIL single_ready_xfer got=%b exp=0", r0_tx_ready); end
    r0_tx_valid = 0; m_busy = 1;
    tick();
    checks++; if ({m_start, ss_n} !== 2'b00) begin failures++;
      $display("FAIL single_start_pulse got=%b exp=00", {m_start, ss_n}); end
    m_done = 1; m_rx_data = 8'h5A; m_busy = 0;
    tick();
    m_done = 0;
    checks++; if ({r0_rx_valid, r1_rx_valid, rx_data} !== {2'b10, 8'h5A}) begin failures++;
      $display("FAIL single_rx0 got=%b%b/%h exp=10/5a", r0_rx_valid, r1_rx_valid, rx_data); end
    checks++; if ({ss_n, r0_tx_ready} !== 2'b01) begin failures++;
      $display("FAIL single_back_hold got=%b exp=01", {ss_n, r0_tx_ready}); end
    r0_tx_valid = 1; r0_tx_data = 8'h3C; r0_last = 1;
    tick();
    checks++; if ({r0_rx_valid, m_start, m_tx_data} !== {2'b01, 8'h3C}) begin failures++;
      $display("FAIL single_start1 got=%b%b/%h exp=01/3c", r0_rx_valid, m_start, m_tx_data); end
    r0_tx_valid = 0; r0_last = 0; m_busy = 1;
    tick();
    m_done = 1; m_rx_data = 8'hC3; m_busy = 0;
    tick();
    m_done = 0; r0_req = 0;
    checks++; if ({r0_rx_valid, rx_data} !== {1'b1, 8'hC3}) begin failures++;
      $display("FAIL single_rx1 got=%b/%h exp=1/c3", r0_rx_valid, rx_data); end
    checks++; if ({ss_n, r0_gnt} !== 2'b10) begin failures++;
      $display("FAIL single_deselect got=%b exp=10", {ss_n, r0_gnt}); end
    tick();
    checks++; if ({ss_n, r0_gnt, r0_rx_valid} !== 3'b100) begin failures++;
      $display("FAIL single_idle got=%b exp=100", {ss_n, r0_gnt, r0_rx_valid}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    r0_req = 1; r1_req = 1;
    tick();
    checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin failures++;
      $display("FAIL rr_first got=%b exp=10", {r0_gnt, r1_gnt}); end
    tick();
    xfer_byte(1'b0, 8'h11, 1'b1, 8'h22);
    checks++; if ({r0_rx_valid, rx_data, ss_n, r0_gnt, r1_gnt} !== {1'b1, 8'h22, 3'b100}) begin
      failures++; $display("FAIL rr_first_done got=%b/%h/%b exp=1/22/100",
        r0_rx_valid, rx_data, {ss_n, r0_gnt, r1_gnt}); end
    r0_req = 0;
    tick();
    checks++; if ({r0_gnt, r1_gnt} !== 2'b00) begin failures++;
      $display("FAIL rr_idle got=%b exp=00", {r0_gnt, r1_gnt}); end
    tick();
    checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin failures++;
      $display("FAIL rr_second got=%b exp=01", {r0_gnt, r1_gnt}); end
    tick();
    checks++; if ({r0_tx_ready, r1_tx_ready} !== 2'b01) begin failures++;
      $display("FAIL rr_second_ready got=%b exp=01", {r0_tx_ready, r1_tx_ready}); end
    xfer_byte(1'b1, 8'h33, 1'b1, 8'h44);
    checks++; if ({r0_rx_valid, r1_rx_valid, rx_data} !== {2'b01, 8'h44}) begin failures++;
      $display("FAIL rr_second_rx got=%b%b/%h exp=01/44", r0_rx_valid, r1_rx_valid, rx_data); end
    r0_req = 1;
    tick();
    tick();
    checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin failures++;
      $display("FAIL rr_third got=%b exp=10", {r0_gnt, r1_gnt}); end
    r0_req = 0; r1_req = 0;
    tick();
    tick();
    checks++; if ({ss_n, r0_gnt} !== 2'b10) begin failures++;
      $display("FAIL rr_release got=%b exp=10", {ss_n, r0_gnt}); end
    tick();
  endtask

  task automatic test_drop_in_xfer();
    int starts = 0;
    int rxv = 0;
    r1_req = 1;
    tick();
    tick();
    r1_tx_valid = 1; r1_tx_data = 8'h77; r1_last = 0;
    tick();
    checks++; if ({m_start, m_tx_data} !== {1'b1, 8'h77}) begin failures++;
      $display("FAIL drop_start got=%b/%h exp=1/77", m_start, m_tx_data); end
    r1_tx_valid = 0; m_busy = 1; r1_req = 0;
    tick();
    checks++; if ({ss_n, r1_gnt} !== 2'b01) begin failures++;
      $display("FAIL drop_still_xfer got=%b exp=01", {ss_n, r1_gnt}); end
    m_done = 1; m_rx_data = 8'h88; m_busy = 0;
    tick();
    m_done = 0;
    checks++; if ({r1_rx_valid, r0_rx_valid, rx_data, ss_n} !== {2'b10, 8'h88, 1'b1}) begin
      failures++; $display("FAIL drop_done got=%b%b/%h/%b exp=10/88/1",
        r1_rx_valid, r0_rx_valid, rx_data, ss_n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      starts += int'(m_start);
      rxv += int'(r1_rx_valid);
    end
    checks++; if (starts !== 0 || rxv !== 0) begin failures++;
      $display("FAIL drop_after got=%0d/%0d exp=0/0", starts, rxv); end
  endtask

  task automatic test_reset_mid_xfer();
    r0_req = 1;
    tick();
    tick();
    r0_tx_valid = 1; r0_tx_data = 8'hA1; r0_last = 0;
    tick();
    r0_tx_valid = 0; m_busy = 1;
    tick();
    tick();
    reset = 1; r0_req = 0;
    #1;
    checks++; if ({ss_n, r0_gnt} !== 2'b10) begin failures++;
      $display("FAIL rstmid_async got=%b exp=10", {ss_n, r0_gnt}); end
    tick();
    reset = 0;
    m_done = 1; m_rx_data = 8'h99; m_busy = 0;
    tick();
    m_done = 0;
    checks++; if ({r0_rx_valid, r1_rx_valid, rx_data, ss_n} !== {2'b00, 8'h00, 1'b1}) begin
      failures++; $display("FAIL rstmid_done got=%b%b/%h/%b exp=00/00/1",
        r0_rx_valid, r1_rx_valid, rx_data, ss_n); end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    r0_req = 1;
    tick();
    r1_req = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (timeout !== (i == 4)) begin failures++;
        $display("FAIL timeout_hold%0d got=%b exp=%b", i, timeout, (i == 4)); end
    end
    tick();
    checks++; if ({timeout, ss_n, r0_gnt} !== 3'b010) begin failures++;
      $display("FAIL timeout_release got=%b exp=010", {timeout, ss_n, r0_gnt}); end
    tick();
    tick();
    checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin failures++;
      $display("FAIL timeout_next_owner got=%b exp=01", {r0_gnt, r1_gnt}); end
  endtask
`else
  task automatic test_hold_forever();
    int bad = 0;
    do_reset();
    r0_req = 1;
    tick();
    tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (timeout !== 1'b0 || ss_n !== 1'b0 || r0_gnt !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL hold_forever bad_cycles got=%0d exp=0", bad); end
    r0_req = 0;
  endtask
`endif

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_drop_in_xfer();
    test_reset_mid_xfer();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter IDLE_LIMIT, default 255: maximum HOLD cycles before forced release; used only with SPI_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rN_req  input  1  (N=0,1), requester N requests or holds the bus.
REQ-005 SHALL have ports rN_gnt  output  1  requester N owns the bus.
REQ-006 SHALL have ports rN_tx_valid  input  1, rN_tx_data  input  8, rN_last  input  1  for the byte offered by requester N, with rN_last marking the final byte of its transaction.
REQ-007 SHALL have ports rN_tx_ready  output  1  byte accept strobe for requester N.
REQ-008 SHALL have ports rN_rx_valid  output  1  one-cycle received-byte strobe to requester N.
REQ-009 SHALL have port rx_data  output  8  last received byte, shared by both requesters.
REQ-010 SHALL have ports m_start  output  1  and m_tx_data  output  8  to start one byte on the SPI master.
REQ-011 SHALL have ports m_busy  input  1, m_done  input  1  (one-cycle pulse), and m_rx_data  input  8  (valid with m_done) from the SPI master.
REQ-012 SHALL have port ss_n  output  1  slave select, active-low.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 SHALL implement states IDLE, SELECT, HOLD, XFER, DESELECT.
REQ-015 IDLE: on any rN_req, SHALL grant one requester, drive ss_n=0, and go to SELECT on the next edge.
REQ-016 Arbitration SHALL be round-robin: if both requests are asserted together, the requester not served last wins; the pointer SHALL update when DESELECT is entered.
REQ-017 SELECT SHALL last exactly one cycle (ss_n setup), then go to HOLD.
REQ-018 HOLD: owner rN_tx_ready=1 iff m_busy=0; a byte SHALL be accepted on the cycle where valid&ready=1.
REQ-019 On acceptance at cycle t, SHALL drive m_start=1 for one cycle at t+1 with m_tx_data equal to the accepted byte, latch rN_last, and enter XFER.
REQ-020 XFER: on m_done, SHALL register m_rx_data into rx_data and pulse owner rN_rx_valid for one cycle on the next cycle.
REQ-021 XFER: on m_done, SHALL go to DESELECT if the latched last=1 or owner rN_req=0; otherwise it SHALL return to HOLD.
REQ-022 HOLD: if owner rN_req=0, SHALL go to DESELECT (no byte in flight).
REQ-023 A requester dropping rN_req during XFER SHALL NOT abort the byte; the byte completes, then DESELECT.
REQ-024 DESELECT SHALL drive ss_n=1 and rN_gnt=0 for exactly one guard cycle, then go to IDLE.
REQ-025 The non-owner SHALL see gnt=0, tx_ready=0 and rx_valid=0 at all times.
REQ-026 rN_gnt SHALL be 1 from SELECT through XFER.
REQ-027 At most one rN_gnt SHALL be 1 at any time.
REQ-028 ss_n SHALL be 0 exactly in SELECT, HOLD and XFER.
REQ-029 m_start SHALL never assert while m_busy=1.
REQ-030 A byte SHALL be accepted back-to-back earliest the cycle after m_done returns to HOLD.

Reset
REQ-031 Asserting reset SHALL force state IDLE, ss_n=1, gnt=0, tx_ready=0, rx_valid=0, m_start=0, m_tx_data=0, rx_data=0, timeout=0, round-robin pointer to favour r0, and timeout counter to 0.
REQ-032 Reset mid-XFER SHALL drop ss_n immediately (asynchronously), and no rx_valid SHALL follow a later m_done.

Configuration
REQ-033 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in HOLD (cleared on entering HOLD).
REQ-034 With SPI_ARB_TIMEOUT_EN defined, when the counter reaches IDLE_LIMIT the block SHALL pulse timeout for one cycle and go to DESELECT.
REQ-035 Without SPI_ARB_TIMEOUT_EN, timeout SHALL be constant 0, no counter SHALL exist, and HOLD SHALL persist indefinitely.

Verification
REQ-036 r0 only, send bytes 0xA5, 0x3C (last=1), m_done returns 0x5A, 0xC3 -> ss_n low for the entire transaction; r0_rx_valid pulses with rx_data 0x5A then 0xC3; ss_n returns to 1 for one DESELECT cycle; r0_gnt=0.
REQ-037 r0_req and r1_req rise in the same cycle after reset -> r0 is granted first; after its last byte, r1 is granted after IDLE; a third simultaneous request goes to r0.
REQ-038 r1 owner drops r1_req in XFER of byte 0x77 -> m_done is still honoured; r1_rx_valid pulses once, then DESELECT; no further m_start.
REQ-039 Reset asserted two cycles after m_start -> ss_n=1 immediately; a later m_done pulse produces no rx_valid.
REQ-040 Macro defined, IDLE_LIMIT=4, owner holds req with no tx_valid -> timeout pulses on the 4th HOLD cycle; ss_n=1 next cycle; the other requester is granted.
REQ-041 Macro undefined, same stimulus for 1000 cycles -> timeout stays 0 and ss_n stays 0.
